fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Producer side of the fetch/decode pipeline interface: owns the PC and issues requests to instruction memory.
- Presents pc_plus_four_f, instruction_f and valid_f to the fetch/decode pipeline register every cycle.
- Honours hazard-unit stall_f and decode-stage branch redirects, including redirects that arrive while a variable-latency memory access is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low two bits must be 00).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall_f  input  1  hazard unit: hold the PC and the current fetch result
- pc_src_d  input  1  decode stage: branch/jump taken this cycle
- pc_branch_d  input  32  redirect target; bits [1:0] ignored and forced to 00
- imem_req  output  1  request valid; held high until imem_ready
- imem_addr  output  32  word address; stable while imem_req is high
- imem_ready  input  1  response valid this cycle; may be asserted in the same cycle as imem_req
- imem_rdata  input  32  instruction word; valid when imem_ready is high
- pc_plus_four_f  output  32  PC+4 of the instruction slot being presented
- instruction_f  output  32  fetched instruction, or NOP (32'h0) when valid_f=0
- valid_f  output  1  instruction_f holds a real fetched word; hazard unit stalls decode when 0

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset, and every cycle reset is high:
  - pc=RESET_PC, state=FETCH, inst_buf=0, redirect_pc=0.
  - Outputs forced to imem_req=0, valid_f=0, instruction_f=0.
  - Reset mid-request abandons the access; memory must tolerate req dropping on reset only.
- pc_plus_four_f = pc+4, modulo 2^32 (wraps at 32'hFFFF_FFFC to 0). imem_addr = pc.
- Redirect is taken only when pc_src_d & !stall_f; a redirect presented during stall_f is ignored, since decode re-presents it after the stall. next_pc = taken ? {pc_branch_d[31:2],2'b00} : pc+4.
- FETCH (imem_req=1):
  - !imem_ready: valid_f=0, instruction_f=NOP; pc holds. A taken redirect loads redirect_pc and moves to DRAIN.
  - imem_ready & !stall_f: valid_f=1, instruction_f=imem_rdata (combinational pass-through); pc<=next_pc; stay in FETCH. Zero-wait memory therefore sustains 1 instr/cycle.
  - imem_ready & stall_f: valid_f=1, instruction_f=imem_rdata; inst_buf<=imem_rdata; go to HOLD.
- HOLD (imem_req=0):
  - valid_f=1, instruction_f=inst_buf.
  - While stall_f: stay.
  - !stall_f: pc<=next_pc, go to FETCH.
- DRAIN (imem_req=1, imem_addr=old pc, valid_f=0, instruction_f=NOP):
  - On imem_ready: discard rdata, pc<=redirect_pc, go to FETCH.
  - A taken redirect in DRAIN overwrites redirect_pc. If it coincides with imem_ready, the new target wins.
- The fetch unit never flushes on a redirect; the instruction presented on a redirect cycle is squashed by the pipeline register's clear.
- imem_addr never changes while imem_req=1 and imem_ready=0 (assertion).

Decomposition:
- Shared include fetch_defines.v holds:
  - state encodings FETCH_S_FETCH=2'd0, FETCH_S_HOLD=2'd1, FETCH_S_DRAIN=2'd2
  - `MIPS_NOP 32'h0000_0000
  - default RESET_PC
- One natural sub-module: pc_register (32-bit register with synchronous reset value and enable), reused for pc and redirect_pc.

Test Plan:
- Zero-wait memory (imem_ready tied to imem_req), no stalls, RESET_PC=0 → imem_addr sequence 0,4,8,C; pc_plus_four_f 4,8,C,10; valid_f=1 from the first cycle after reset.
- 3-cycle memory latency → valid_f=0 and instruction_f=0 for 2 cycles, then imem_rdata with valid_f=1; imem_addr held constant throughout.
- imem_ready coincident with stall_f for 3 cycles → HOLD; instruction_f equals the buffered word with imem_req=0; pc advances exactly once after stall_f drops.
- Redirect pc_src_d=1, pc_branch_d=32'h100, issued during an outstanding 4-cycle access at 0x8 → imem_addr stays 0x8 until ready, response discarded, next imem_addr=0x100.
- Two redirects during DRAIN (0x100, then 0x200 with imem_ready) → next imem_addr=0x200. pc_src_d with stall_f=1 → ignored.
- Reset asserted mid-access and pc=32'hFFFF_FFFC wrap → imem_req=0 during reset and restart at RESET_PC; pc_plus_four_f=0 at wrap.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_S_FETCH = 2'd0,
        FETCH_S_HOLD  = 2'd1,
        FETCH_S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_register.sv
// Register with synchronous active-high reset value and load enable; used for pc and redirect_pc.
module pc_register #(
    parameter int unsigned        WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues requests to instruction memory and presents the fetched word to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_four_f,
    output logic [31:0] instruction_f,
    output logic        valid_f
);

    fetch_state_e state, state_next;

    logic [31:0] pc, pc_d, pc_plus_four;
    logic [31:0] redirect_pc, branch_target;
    logic [31:0] inst_buf;
    logic        pc_en, redirect_en, buf_en, taken;

    // A redirect seen during a stall is dropped; decode re-presents it once the stall clears.
    assign taken          = pc_src_d & ~stall_f;
    assign branch_target  = word_align(pc_branch_d);
    assign pc_plus_four   = pc + 32'd4;
    assign pc_plus_four_f = pc_plus_four;
    assign imem_addr      = pc;

    pc_register #(.WIDTH(32), .RESET_VALUE(RESET_PC)) u_pc (
        .clock  (clock),
        .reset  (reset),
        .enable (pc_en),
        .d      (pc_d),
        .q      (pc)
    );

    pc_register #(.WIDTH(32), .RESET_VALUE(32'h0)) u_redirect_pc (
        .clock  (clock),
        .reset  (reset),
        .enable (redirect_en),
        .d      (branch_target),
        .q      (redirect_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH_S_FETCH;
            inst_buf <= MIPS_NOP;
        end else begin
            state <= state_next;
            if (buf_en) begin
                inst_buf <= imem_rdata;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        pc_en         = 1'b0;
        pc_d          = taken ? branch_target : pc_plus_four;
        redirect_en   = 1'b0;
        buf_en        = 1'b0;
        imem_req      = 1'b0;
        valid_f       = 1'b0;
        instruction_f = MIPS_NOP;

        case (state)
            FETCH_S_FETCH: begin
                imem_req = 1'b1;
                if (!imem_ready) begin
                    if (taken) begin
                        redirect_en = 1'b1;
                        state_next  = FETCH_S_DRAIN;
                    end
                end else begin
                    valid_f       = 1'b1;
                    instruction_f = imem_rdata;
                    if (stall_f) begin
                        buf_en     = 1'b1;
                        state_next = FETCH_S_HOLD;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            FETCH_S_HOLD: begin
                valid_f       = 1'b1;
                instruction_f = inst_buf;
                if (!stall_f) begin
                    pc_en      = 1'b1;
                    state_next = FETCH_S_FETCH;
                end
            end
            FETCH_S_DRAIN: begin
                // The stale access must complete at the old address; its data is thrown away.
                imem_req    = 1'b1;
                redirect_en = taken;
                if (imem_ready) begin
                    pc_en      = 1'b1;
                    pc_d       = taken ? branch_target : redirect_pc;
                    state_next = FETCH_S_FETCH;
                end
            end
            default: begin
                state_next = FETCH_S_FETCH;
            end
        endcase

        if (reset) begin
            imem_req      = 1'b0;
            valid_f       = 1'b0;
            instruction_f = MIPS_NOP;
        end
    end

    property p_addr_stable;
        @(posedge clock) disable iff (reset)
            (imem_req && !imem_ready) |=> (imem_addr == $past(imem_addr));
    endproperty

    a_addr_stable: assert property (p_addr_stable);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-configurable memory model plus an in-order instruction scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        pc_src_d = 1'b0;
    logic [31:0] pc_branch_d = 32'h0;
    logic        imem_req, imem_ready, valid_f;
    logic [31:0] imem_addr, imem_rdata, pc_plus_four_f, instruction_f;

    int   checks = 0;
    int   errors = 0;
    int   latency = 1;
    int   wait_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_f        (stall_f),
        .pc_src_d       (pc_src_d),
        .pc_branch_d    (pc_branch_d),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .pc_plus_four_f (pc_plus_four_f),
        .instruction_f  (instruction_f),
        .valid_f        (valid_f)
    );

    // Memory model: ready in the latency-th cycle of a request; data is a fixed function of the address.
    assign imem_rdata = imem_addr ^ MAGIC;
    assign imem_ready = imem_req && (wait_cnt >= latency - 1);

    always @(posedge clock) begin
        if (reset || !imem_req || imem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Scoreboard: every instruction decode accepts (valid_f && !stall_f) must match the next expectation.
    always @(negedge clock) begin
        if (!reset && valid_f && !stall_f) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr %h pc4 %h, required no instruction", instruction_f, pc_plus_four_f);
            end else begin
                mon_e = exp_q.pop_front();
                if (instruction_f !== mon_e.instr || pc_plus_four_f !== mon_e.pc4) begin
                    errors++;
                    $display("FAIL sb_instr: got instr %h pc4 %h, required instr %h pc4 %h",
                             instruction_f, pc_plus_four_f, mon_e.instr, mon_e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc4, input logic [31:0] addr);
        exp_t e;
        e.pc4   = pc4;
        e.instr = addr ^ MAGIC;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall_f     = 1'b0;
        pc_src_d    = 1'b0;
        pc_branch_d = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic park();
        reset    = 1'b1;
        stall_f  = 1'b0;
        pc_src_d = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expectations, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        latency = 1;
        reset   = 1'b1;
        tick();
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        checks++; if (valid_f !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid_f); end
        checks++; if (instruction_f !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, required 0", instruction_f); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", imem_addr); end
        checks++; if (pc_plus_four_f !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h, required 4", pc_plus_four_f); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        latency = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 32'(i * 4);
            push_exp(a + 32'd4, a);
            @(negedge clock);
            checks++; if (imem_addr !== a) begin errors++; $display("FAIL zw_addr: got %h, required %h", imem_addr, a); end
            checks++; if (pc_plus_four_f !== a + 32'd4) begin errors++; $display("FAIL zw_pc4: got %h, required %h", pc_plus_four_f, a + 32'd4); end
            checks++; if (valid_f !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b, required 1", valid_f); end
            tick();
        end
        park();
    endtask

    task automatic test_latency();
        latency = 3;
        do_reset();
        push_exp(32'h4, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (imem_addr !== ((c < 3) ? 32'h0 : 32'h4)) begin
                errors++; $display("FAIL lat_addr c%0d: got %h, required %h", c, imem_addr, (c < 3) ? 32'h0 : 32'h4);
            end
            if (c == 2) begin
                checks++; if (valid_f !== 1'b1) begin errors++; $display("FAIL lat_valid c%0d: got %b, required 1", c, valid_f); end
            end else begin
                checks++; if (valid_f !== 1'b0) begin errors++; $display("FAIL lat_valid c%0d: got %b, required 0", c, valid_f); end
                checks++; if (instruction_f !== 32'h0) begin errors++; $display("FAIL lat_nop c%0d: got %h, required 0", c, instruction_f); end
            end
            tick();
        end
        park();
    endtask

    task automatic test_stall_hold();
        latency = 1;
        do_reset();
        stall_f = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++; if (valid_f !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d: got %b, required 1", c, valid_f); end
            checks++; if (instruction_f !== MAGIC) begin errors++; $display("FAIL hold_instr c%0d: got %h, required %h", c, instruction_f, MAGIC); end
            checks++; if (imem_req !== (c == 0)) begin errors++; $display("FAIL hold_req c%0d: got %b, required %b", c, imem_req, c == 0); end
            checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL hold_addr c%0d: got %h, required 0", c, imem_addr); end
            tick();
        end
        stall_f = 1'b0;
        push_exp(32'h4, 32'h0);
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_release_req: got %b, required 0", imem_req); end
        tick();
        push_exp(32'h8, 32'h4);
        @(negedge clock);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL hold_advance: got %h, required 4", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_refetch_req: got %b, required 1", imem_req); end
        tick();
        park();
    endtask

    task automatic test_redirect_drain();
        bit found = 1'b0;
        latency = 4;
        do_reset();
        push_exp(32'h4, 32'h0);
        push_exp(32'h8, 32'h4);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (imem_addr === 32'h8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL drain_reach8: got addr %h, required 8 within 20 cycles", imem_addr); end
        tick();
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h100;
        for (int c = 1; c < 4; c++) begin
            @(negedge clock);
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL drain_addr c%0d: got %h, required 8", c, imem_addr); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_req c%0d: got %b, required 1", c, imem_req); end
            checks++; if (valid_f !== 1'b0) begin errors++; $display("FAIL drain_valid c%0d: got %b, required 0", c, valid_f); end
            tick();
            pc_src_d = 1'b0;
        end
        @(negedge clock);
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL drain_target: got %h, required 100", imem_addr); end
        tick();
        park();
    endtask

    task automatic test_double_redirect();
        latency = 4;
        do_reset();
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h100;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                pc_src_d    = 1'b1;
                pc_branch_d = 32'h203;
            end
            @(negedge clock);
            checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL dbl_addr c%0d: got %h, required 0", c, imem_addr); end
            checks++; if (valid_f !== 1'b0) begin errors++; $display("FAIL dbl_valid c%0d: got %b, required 0", c, valid_f); end
            tick();
            pc_src_d = 1'b0;
        end
        stall_f     = 1'b1;
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h300;
        push_exp(32'h204, 32'h200);
        for (int c = 4; c < 8; c++) begin
            @(negedge clock);
            checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL dbl_newest c%0d: got %h, required 200", c, imem_addr); end
            tick();
            stall_f  = 1'b0;
            pc_src_d = 1'b0;
        end
        @(negedge clock);
        checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL stall_redirect_ignored: got %h, required 204", imem_addr); end
        tick();
        park();
    endtask

    task automatic test_reset_wrap();
        latency = 4;
        do_reset();
        @(negedge clock);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_req_before: got %b, required 1", imem_req); end
        tick();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %b, required 0", imem_req); end
        checks++; if (valid_f !== 1'b0 || instruction_f !== 32'h0) begin
            errors++; $display("FAIL mid_reset_out: got valid %b instr %h, required 0 0", valid_f, instruction_f);
        end
        tick();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL restart: got req %b addr %h, required 1 0", imem_req, imem_addr);
        end
        tick();
        park();

        latency = 1;
        do_reset();
        pc_src_d    = 1'b1;
        pc_branch_d = 32'hFFFF_FFFC;
        push_exp(32'h4, 32'h0);
        @(negedge clock);
        tick();
        pc_src_d = 1'b0;
        push_exp(32'h0, 32'hFFFF_FFFC);
        @(negedge clock);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h, required fffffffc", imem_addr); end
        checks++; if (pc_plus_four_f !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h, required 0", pc_plus_four_f); end
        tick();
        push_exp(32'h4, 32'h0);
        @(negedge clock);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h, required 0", imem_addr); end
        tick();
        park();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_drain();
        test_double_redirect();
        test_reset_wrap();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
